// File: rtl/mura_step_sequencer_pkg.sv
// Shared definitions for the step sequencer: one-hot state codes and the
// width helper for the response ones counter.
package mura_step_sequencer_pkg;

    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_CLEAR  = 6'b000010;
    localparam logic [5:0] ST_WAIT   = 6'b000100;
    localparam logic [5:0] ST_STEP   = 6'b001000;
    localparam logic [5:0] ST_SAMPLE = 6'b010000;
    localparam logic [5:0] ST_DONE   = 6'b100000;

    function automatic int ones_cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/step_gap_timer.sv
// Inter-step gap timer: after a load, expire pulses once div cycles later;
// with div=0 it expires combinationally in the load cycle itself.
module step_gap_timer #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [DIV_W-1:0] div_last;
    logic             at_end;

    assign div_last = div - DIV_W'(1);
    assign at_end   = (cnt_q == div_last);

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = '0;
            run_d = (div != '0);
        end else if (run_q) begin
            if (at_end) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire = load ? (div == '0) : (run_q && at_end);

endmodule

// File: rtl/mura_step_sequencer.sv
// Drives one Moore automaton through a latched LEN-bit pattern, one enable
// pulse per step, and records the automaton output after every step.
module mura_step_sequencer
    import mura_step_sequencer_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int DIV_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [LEN-1:0]               pattern,
    input  logic [DIV_W-1:0]             div,
    input  logic                         fsm_y,
    output logic                         fsm_en,
    output logic                         fsm_a,
    output logic                         fsm_rst_n,
    output logic                         busy,
    output logic                         done,
    output logic [LEN-1:0]               resp,
    output logic [ones_cnt_w(LEN)-1:0]   ones_cnt
);

    localparam int                CNT_W    = ones_cnt_w(LEN);
    localparam int                IDX_W    = $clog2(LEN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LEN - 1);

    logic [5:0]       state_q, state_d;
    logic             clr_n_q, clr_n_d;
    logic [LEN-1:0]   pat_q;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [LEN-1:0]   resp_q;
    logic [CNT_W-1:0] ones_q;
    logic             last_step;
    logic             gap_load;
    logic             gap_expire;

    assign last_step = (idx_q == IDX_LAST);
    // Reload the gap ahead of every step so a zero gap goes straight to STEP.
    assign gap_load  = (state_q == ST_CLEAR) || ((state_q == ST_SAMPLE) && !last_step);

    step_gap_timer #(.DIV_W(DIV_W)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (gap_load),
        .div    (div_q),
        .expire (gap_expire)
    );

    always_comb begin
        state_d = state_q;
        fsm_en  = 1'b0;
        fsm_a   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                state_d = gap_expire ? ST_STEP : ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (gap_expire) state_d = ST_STEP;
            end
            ST_STEP: begin
                busy    = 1'b1;
                fsm_en  = 1'b1;
                fsm_a   = pat_q[idx_q];
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy    = 1'b1;
                state_d = last_step ? ST_DONE : (gap_expire ? ST_STEP : ST_WAIT);
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
        clr_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            clr_n_q <= 1'b1;
            pat_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            resp_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            clr_n_q <= clr_n_d;
            if ((state_q == ST_IDLE) && start) begin
                pat_q <= pattern;
                div_q <= div;
            end
            if (state_q == ST_CLEAR) begin
                idx_q  <= '0;
                resp_q <= '0;
                ones_q <= '0;
            end
            // The sample of the current step lands even if abort arrives with it.
            if (state_q == ST_SAMPLE) begin
                resp_q[idx_q] <= fsm_y;
                ones_q        <= ones_q + CNT_W'(fsm_y);
                if (!last_step) idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign fsm_rst_n = rst_n & clr_n_q;
    assign resp      = resp_q;
    assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_mura_step_sequencer.sv
// Bench for mura_step_sequencer with the 3-state test automaton attached and a
// timeline model of the sequencer checked every cycle.
module tb_mura_step_sequencer;

    localparam int LEN   = 8;
    localparam int DIV_W = 4;
    localparam int BIG   = 32'h3fff_ffff;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN-1:0]   pattern = '0;
    logic [DIV_W-1:0] div = '0;
    logic             fsm_y;
    logic             fsm_en, fsm_a, fsm_rst_n, busy, done;
    logic [LEN-1:0]   resp;
    logic [3:0]       ones_cnt;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    mura_step_sequencer #(.LEN(LEN), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .div       (div),
        .fsm_y     (fsm_y),
        .fsm_en    (fsm_en),
        .fsm_a     (fsm_a),
        .fsm_rst_n (fsm_rst_n),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .ones_cnt  (ones_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached automaton: S0->S1->S2->S0 on a=1, y=1 in S1 and S2.
    logic [1:0] aut_q;
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) aut_q <= 2'd0;
        else if (fsm_en && fsm_a) aut_q <= (aut_q == 2'd2) ? 2'd0 : aut_q + 2'd1;
    end
    assign fsm_y = (aut_q != 2'd0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- model: run timeline derived from the start edge ----------------
    bit             has_run = 0;
    int             m_s = 0, m_a = BIG, m_d = 0;
    logic [LEN-1:0] m_pat = '0;
    logic [LEN-1:0] prev_resp = '0;
    logic [3:0]     prev_ones = '0;
    int             m_e;
    bit             m_running;
    logic [LEN-1:0] tmp_r;
    logic [3:0]     tmp_o;

    function automatic logic [LEN-1:0] ideal_resp(input logic [LEN-1:0] p);
        int             c = 0;
        logic [LEN-1:0] r = '0;
        logic [LEN-1:0] sh;
        for (int k = 0; k < LEN; k++) begin
            sh = p >> k;
            if (sh[0]) c = (c + 1) % 3;
            if (c != 0) r = r | (LEN'(1) << k);
        end
        return r;
    endfunction

    function automatic void model_resp(input int t, output logic [LEN-1:0] r, output logic [3:0] o);
        logic [LEN-1:0] id;
        logic [LEN-1:0] sh;
        int lim;
        r = prev_resp;
        o = prev_ones;
        if (!has_run || (t - m_s) <= 0) return;
        id  = ideal_resp(m_pat);
        lim = (t < m_a) ? t : m_a;
        r = '0;
        o = '0;
        for (int k = 0; k < LEN; k++) begin
            if (m_s + 1 + k * (m_d + 2) + m_d + 1 < lim) begin
                sh = id >> k;
                if (sh[0]) begin
                    r = r | (LEN'(1) << k);
                    o = o + 4'd1;
                end
            end
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            has_run   = 0;
            prev_resp = '0;
            prev_ones = '0;
        end else begin
            m_e = cyc + 1;
            m_running = has_run && (m_e - 1 >= m_s) && (m_e - 1 <= m_s + LEN * (m_d + 2) + 1)
                        && (m_e - 1 < m_a);
            if (!m_running) begin
                if (start) begin
                    model_resp(m_e, tmp_r, tmp_o);
                    prev_resp = tmp_r;
                    prev_ones = tmp_o;
                    has_run = 1;
                    m_s = m_e;
                    m_a = BIG;
                    m_d = int'(div);
                    m_pat = pattern;
                end
            end else if (abort) begin
                m_a = m_e;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic           e_busy, e_done, e_en, e_a, e_frst;
    logic [LEN-1:0] e_resp, sh_pat;
    logic [3:0]     e_ones;
    int             rel, span;
    bit             live, prev_en = 0;
    int             en_total = 0, en_wide = 0, done_total = 0;
    int             en_q[$];

    initial forever begin
        @(negedge clk);
        e_busy = 0; e_done = 0; e_en = 0; e_a = 0; e_frst = rst_n;
        e_resp = '0; e_ones = '0;
        if (rst_n) begin
            model_resp(cyc, e_resp, e_ones);
            if (has_run) begin
                rel  = cyc - m_s;
                live = (cyc < m_a);
                span = LEN * (m_d + 2);
                if (live && rel >= 0 && rel <= span) e_busy = 1;
                if (live && rel == span + 1) e_done = 1;
                if (rel == 0) e_frst = 0;
                if (live && rel >= 1 && rel <= span && ((rel - 1) % (m_d + 2)) == m_d) begin
                    e_en   = 1;
                    sh_pat = m_pat >> ((rel - 1) / (m_d + 2));
                    e_a    = sh_pat[0];
                end
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("fsm_en", 32'(fsm_en), 32'(e_en));
        chk("fsm_a", 32'(fsm_a), 32'(e_a));
        chk("fsm_rst_n", 32'(fsm_rst_n), 32'(e_frst));
        chk("resp", 32'(resp), 32'(e_resp));
        chk("ones_cnt", 32'(ones_cnt), 32'(e_ones));
        if (fsm_en) begin
            en_total++;
            en_q.push_back(cyc);
            if (prev_en) en_wide++;
        end
        if (done) done_total++;
        prev_en = fsm_en;
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_run(input logic [LEN-1:0] p, input logic [DIV_W-1:0] d, output int s_edge);
        @(posedge clk);
        #1;
        pattern = p;
        div     = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        s_edge = cyc;
        start  = 1'b0;
        $display("run start pattern=%02h div=%0d edge=%0d", p, d, s_edge);
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) chk("done_seen", 32'd0, 32'd1);
    endtask

    int s, dc, e0, w0, q0, d0;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        chk("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd1);

        // All ones, no gap.
        do_run(8'hFF, 4'd0, s);
        wait_done(100, dc);
        chk("s1_done_lat", 32'(dc - s), 32'd17);
        chk("s1_resp", 32'(resp), 32'hDB);
        chk("s1_ones", 32'(ones_cnt), 32'd6);
        $display("s1 resp=%02h ones=%0d lat=%0d", resp, ones_cnt, dc - s);

        // All zeros: eight single-cycle enable pulses.
        e0 = en_total; w0 = en_wide;
        do_run(8'h00, 4'd0, s);
        wait_done(100, dc);
        chk("s2_resp", 32'(resp), 32'h00);
        chk("s2_ones", 32'(ones_cnt), 32'd0);
        chk("s2_en_pulses", 32'(en_total - e0), 32'd8);
        chk("s2_en_wide", 32'(en_wide - w0), 32'd0);
        $display("s2 resp=%02h ones=%0d pulses=%0d", resp, ones_cnt, en_total - e0);

        // Gap of 3 cycles between steps.
        q0 = en_q.size();
        do_run(8'h05, 4'd3, s);
        wait_done(200, dc);
        chk("s3_done_lat", 32'(dc - s), 32'd41);
        chk("s3_resp", 32'(resp), 32'hFF);
        chk("s3_ones", 32'(ones_cnt), 32'd8);
        chk("s3_en_pulses", 32'(en_q.size() - q0), 32'd8);
        for (int i = q0 + 1; i < en_q.size(); i++) chk("s3_en_gap", 32'(en_q[i] - en_q[i-1]), 32'd5);
        $display("s3 resp=%02h ones=%0d lat=%0d", resp, ones_cnt, dc - s);

        // Abort in the SAMPLE cycle of step index 3.
        do_run(8'hFF, 4'd0, s);
        wait_cyc(s + 8);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_resp", 32'(resp), 32'h0B);
        chk("s4_ones", 32'(ones_cnt), 32'd3);
        d0 = done_total;
        repeat (20) @(posedge clk);
        #1;
        chk("s4_no_done", 32'(done_total - d0), 32'd0);
        $display("s4 abort resp=%02h ones=%0d", resp, ones_cnt);
        do_run(8'hFF, 4'd0, s);
        wait_done(100, dc);
        chk("s4b_resp", 32'(resp), 32'hDB);
        chk("s4b_ones", 32'(ones_cnt), 32'd6);

        // Start and operand changes while busy must not disturb the run.
        do_run(8'h5A, 4'd2, s);
        wait_cyc(s + 5);
        start = 1'b1; pattern = 8'hFF; div = 4'd0;
        wait_cyc(s + 10);
        start = 1'b0;
        wait_done(200, dc);
        chk("s5_done_lat", 32'(dc - s), 32'd33);
        chk("s5_resp", 32'(resp), 32'hCE);
        chk("s5_ones", 32'(ones_cnt), 32'd5);
        $display("s5 resp=%02h ones=%0d lat=%0d", resp, ones_cnt, dc - s);

        // Asynchronous reset mid-run.
        do_run(8'hFF, 4'd1, s);
        wait_cyc(s + 7);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_fsm_en", 32'(fsm_en), 32'd0);
        chk("s6_resp", 32'(resp), 32'd0);
        chk("s6_ones", 32'(ones_cnt), 32'd0);
        chk("s6_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("s6_post_busy", 32'(busy), 32'd0);
        chk("s6_post_fsm_rst_n", 32'(fsm_rst_n), 32'd1);
        $display("s6 reset applied and released");
        do_run(8'hFF, 4'd1, s);
        wait_done(200, dc);
        chk("s6b_done_lat", 32'(dc - s), 32'd25);
        chk("s6b_resp", 32'(resp), 32'hDB);
        chk("s6b_ones", 32'(ones_cnt), 32'd6);
        $display("s6b resp=%02h ones=%0d lat=%0d", resp, ones_cnt, dc - s);

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
